// File: rtl/spi_frame_packer_if.sv
// Sample-stream and SPI-master byte handshake bundle for spi_frame_packer.
// slave = the packer itself; master = the environment (feeder + SPI master).
interface spi_frame_packer_if;
  logic [47:0] s_sample;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  o_tx_byte;
  logic        o_tx_dv;
  logic        i_tx_ready;

  modport slave  (input  s_sample, s_valid, i_tx_ready,
                  output s_ready, o_tx_byte, o_tx_dv);
  modport master (output s_sample, s_valid, i_tx_ready,
                  input  s_ready, o_tx_byte, o_tx_dv);
endinterface

// File: rtl/spi_frame_packer.sv
// Buffers 48-bit FFT samples and emits each as an 8-byte SPI frame (6 data MSB-first + 2 pad),
// one byte per master handshake, with a fixed idle gap between frames and a per-block frame count.
module spi_frame_packer #(
  parameter int          FIFO_DEPTH       = 16,
  parameter int          GAP_CYCLES       = 2_000_000,
  parameter int          FRAMES_PER_BLOCK = 1024,
  parameter logic [7:0]  PAD_BYTE         = 8'hAB
) (
  input  logic                                CLK100MHZ,
  input  logic                                rst_n,
  input  logic                                i_enable,
  spi_frame_packer_if.slave                   bus,
  output logic [$clog2(FRAMES_PER_BLOCK):0]   o_frame_count,
  output logic                                o_block_done,
  output logic [$clog2(FIFO_DEPTH):0]         o_fifo_level,
  output logic                                o_overflow
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int FCW = $clog2(FRAMES_PER_BLOCK) + 1;
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAMES_PER_BLOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t         state;
  logic [47:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [47:0]    head, shadow;
  logic [2:0]     byte_idx;
  logic [GW-1:0]  gap_cnt;
  logic           full, push, pop;

  assign full        = (o_fifo_level == LW'(FIFO_DEPTH));
  assign bus.s_ready = ~full;
  assign push        = bus.s_valid & ~full;
  assign pop         = (state == S_LOAD);
  assign head        = mem[rd_ptr];

  function automatic logic [7:0] byte_sel(input logic [47:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    byte_sel = w[47:40];
      3'd1:    byte_sel = w[39:32];
      3'd2:    byte_sel = w[31:24];
      3'd3:    byte_sel = w[23:16];
      3'd4:    byte_sel = w[15:8];
      3'd5:    byte_sel = w[7:0];
      default: byte_sel = PAD_BYTE;
    endcase
  endfunction

  always_ff @(posedge CLK100MHZ)
    if (push) mem[wr_ptr] <= bus.s_sample;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   o_fifo_level <= o_fifo_level + LW'(1);
        2'b01:   o_fifo_level <= o_fifo_level - LW'(1);
        default: ;
      endcase
      if (bus.s_valid && full) o_overflow <= 1'b1;
    end
  end

  // S_LOAD issues byte 0 straight from the FIFO head so the first strobe lands
  // two edges after the push; the cycle before LOAD is always strobe-free.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      shadow        <= '0;
      byte_idx      <= '0;
      gap_cnt       <= '0;
      bus.o_tx_dv   <= 1'b0;
      bus.o_tx_byte <= 8'h00;
      o_frame_count <= '0;
      o_block_done  <= 1'b0;
    end else begin
      bus.o_tx_dv  <= 1'b0;
      o_block_done <= 1'b0;
      case (state)
        S_IDLE:
          if (i_enable && o_fifo_level != '0) state <= S_LOAD;
        S_LOAD: begin
          shadow <= head;
          state  <= S_SEND;
          if (bus.i_tx_ready) begin
            bus.o_tx_dv   <= 1'b1;
            bus.o_tx_byte <= head[47:40];
            byte_idx      <= 3'd1;
          end else begin
            byte_idx      <= 3'd0;
          end
        end
        S_SEND:
          // Skipping the cycle after a strobe covers the master's late Ready drop.
          if (bus.i_tx_ready && !bus.o_tx_dv) begin
            bus.o_tx_dv   <= 1'b1;
            bus.o_tx_byte <= byte_sel(shadow, byte_idx);
            byte_idx      <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
        S_GAP:
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            if (o_frame_count == FC_LAST) begin
              o_frame_count <= '0;
              o_block_done  <= 1'b1;
            end else begin
              o_frame_count <= o_frame_count + FCW'(1);
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
